// File: rtl/tx_link_arbiter_pkg.sv
// rtl/tx_link_arbiter_pkg.sv - shared state encodings and framing constants for tx_link_arbiter
package tx_link_arbiter_pkg;

  typedef enum logic [6:0] {
    IDLE       = 7'b000_0001,
    HDR        = 7'b000_0010,
    READ       = 7'b000_0100,
    WAIT_VALID = 7'b000_1000,
    SEND       = 7'b001_0000,
    WAIT_TX    = 7'b010_0000,
    TRL        = 7'b100_0000
  } linkStateT;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam logic [3:0] TRL_NIBBLE = 4'h5;

  function automatic logic [7:0] frameByte(input logic [3:0] nibble, input logic src);
    return {nibble, 3'b000, src};
  endfunction

endpackage

// File: rtl/tx_link_arbiter_rr.sv
// rtl/tx_link_arbiter_rr.sv - two-way round-robin selector, one-hot grant
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_link_arbiter.sv
// rtl/tx_link_arbiter.sv - arbitrates two byte sources onto one UART, framing each burst with header/trailer
module tx_link_arbiter
  import tx_link_arbiter_pkg::*;
#(
  parameter int MAX_BURST     = 256,
  parameter int VALID_TIMEOUT = 16
) (
  input  logic       SysClk,
  input  logic       ResetN,
  input  logic [1:0] SrcReady,
  input  logic [1:0] SrcValid,
  input  logic [7:0] SrcData0,
  input  logic [7:0] SrcData1,
  output logic [1:0] SrcRdEn,
  input  logic       TxBusy,
  output logic       TxStart,
  output logic [7:0] TxData,
  output logic [1:0] Grant,
  output logic       TimeoutErr
);

  localparam int TW = $clog2(VALID_TIMEOUT + 1);
  localparam logic [8:0]    BURST_LIMIT = 9'(MAX_BURST);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(VALID_TIMEOUT - 1);
  localparam logic [TW-1:0] TOUT_ONE    = TW'(1);

  linkStateT stateQ, stateD, retQ;
  logic srcQ, lastQ, servedQ, txFirstQ, payloadQ;
  logic [8:0]    burstQ;
  logic [TW-1:0] toutQ;
  logic [1:0]    rrGnt;
  logic          arbLast, validHit, readyHit, canRead, timeoutHit;
  logic [7:0]    srcByte;

  // Until something has been served, pretend source 1 went last so source 0 wins a tie.
  assign arbLast = servedQ ? lastQ : 1'b1;

  rr_arbiter2 uArb (
    .req (SrcReady),
    .last(arbLast),
    .gnt (rrGnt)
  );

  assign validHit   = srcQ ? SrcValid[1] : SrcValid[0];
  assign readyHit   = srcQ ? SrcReady[1] : SrcReady[0];
  assign srcByte    = srcQ ? SrcData1 : SrcData0;
  assign canRead    = readyHit && (burstQ < BURST_LIMIT);
  assign timeoutHit = (toutQ == TOUT_LAST);

  always_comb begin
    stateD  = stateQ;
    SrcRdEn = 2'b00;
    TxStart = 1'b0;
    case (stateQ)
      IDLE:       if (|SrcReady) stateD = HDR;
      HDR:        stateD = SEND;
      READ: begin
        if (canRead) begin
          SrcRdEn = srcQ ? 2'b10 : 2'b01;
          stateD  = WAIT_VALID;
        end else begin
          stateD = TRL;
        end
      end
      // Data wins over an expiring timeout in the same cycle.
      WAIT_VALID: begin
        if (validHit)        stateD = SEND;
        else if (timeoutHit) stateD = TRL;
      end
      SEND: begin
        if (!TxBusy) begin
          TxStart = 1'b1;
          stateD  = WAIT_TX;
        end
      end
      WAIT_TX:    if (!txFirstQ && !TxBusy) stateD = retQ;
      TRL:        stateD = SEND;
      default:    stateD = IDLE;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (!ResetN) begin
      stateQ     <= IDLE;
      retQ       <= IDLE;
      srcQ       <= 1'b0;
      lastQ      <= 1'b0;
      servedQ    <= 1'b0;
      txFirstQ   <= 1'b0;
      payloadQ   <= 1'b0;
      burstQ     <= '0;
      toutQ      <= '0;
      Grant      <= 2'b00;
      TxData     <= 8'h00;
      TimeoutErr <= 1'b0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        IDLE: begin
          if (|SrcReady) begin
            Grant <= rrGnt;
            srcQ  <= rrGnt[1];
          end
        end
        HDR: begin
          TxData   <= frameByte(HDR_NIBBLE, srcQ);
          retQ     <= READ;
          payloadQ <= 1'b0;
        end
        READ:       toutQ <= '0;
        WAIT_VALID: begin
          if (validHit) begin
            TxData   <= srcByte;
            retQ     <= READ;
            payloadQ <= 1'b1;
          end else if (timeoutHit) begin
            TimeoutErr <= 1'b1;
          end else begin
            toutQ <= toutQ + TOUT_ONE;
          end
        end
        // Only payload bytes count against the burst limit.
        SEND: begin
          if (!TxBusy) begin
            txFirstQ <= 1'b1;
            if (payloadQ) burstQ <= burstQ + 9'd1;
          end
        end
        WAIT_TX: begin
          txFirstQ <= 1'b0;
          if (!txFirstQ && !TxBusy && retQ == IDLE) begin
            Grant   <= 2'b00;
            burstQ  <= '0;
            lastQ   <= srcQ;
            servedQ <= 1'b1;
          end
        end
        TRL: begin
          TxData   <= frameByte(TRL_NIBBLE, srcQ);
          retQ     <= IDLE;
          payloadQ <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb/tb_tx_link_arbiter.sv - self-checking bench for tx_link_arbiter
module tb_tx_link_arbiter;

  localparam int MAXB = 4;

  logic       SysClk, ResetN;
  logic [1:0] SrcReady, SrcValid, SrcRdEn, Grant;
  logic [7:0] SrcData0, SrcData1, TxData;
  logic       TxBusy, TxStart, TimeoutErr;

  tx_link_arbiter #(.MAX_BURST(MAXB), .VALID_TIMEOUT(16)) dut (
    .SysClk(SysClk), .ResetN(ResetN), .SrcReady(SrcReady), .SrcValid(SrcValid),
    .SrcData0(SrcData0), .SrcData1(SrcData1), .SrcRdEn(SrcRdEn), .TxBusy(TxBusy),
    .TxStart(TxStart), .TxData(TxData), .Grant(Grant), .TimeoutErr(TimeoutErr)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  int checks = 0;
  int failures = 0;

  logic [7:0] q0[$], q1[$], m0[$], m1[$], expQ[$], gotQ[$];
  int  vDelay = 0;
  int  busyMode = 0;
  bit  spurious = 0;
  logic mLast = 1'b0;
  bit  mServed = 0;
  int  cyc = 0, rdCyc = 0, rdCount = 0, toSeen = -1;

  typedef struct { int n0; int n1; int expStarts; } vecT;
  vecT tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge SysClk);
  endtask

  function automatic int pickDelay();
    return (vDelay > 0) ? vDelay : int'($urandom_range(1, 4));
  endfunction

  // Source model, transmitter model and output monitor.
  initial begin : drv
    logic [1:0] rdSeen;
    logic [1:0] pend;
    int         pcnt[2];
    logic [7:0] pdata[2];
    SrcReady = 2'b00; SrcValid = 2'b00; SrcData0 = 8'h00; SrcData1 = 8'h00;
    TxBusy = 1'b0; pend = 2'b00;
    forever begin
      @(negedge SysClk);
      rdSeen = SrcRdEn;
      if (TxStart) begin
        gotQ.push_back(TxData);
        check("txstart_while_busy", {31'd0, TxBusy}, 32'd0);
      end
      if (SrcRdEn != 2'b00) begin
        check("rden_vs_grant", {30'd0, SrcRdEn & ~Grant} | {31'd0, &SrcRdEn}, 32'd0);
        rdCount++;
        rdCyc = cyc;
      end
      if (TimeoutErr && toSeen < 0) toSeen = cyc;
      cyc++;
      @(posedge SysClk);
      #1;
      SrcValid = 2'b00;
      if (!ResetN) pend = 2'b00;
      if (rdSeen[0] && q0.size() > 0) begin
        pdata[0] = q0.pop_front();
        if (vDelay >= 0) begin pend[0] = 1'b1; pcnt[0] = pickDelay(); end
      end
      if (rdSeen[1] && q1.size() > 0) begin
        pdata[1] = q1.pop_front();
        if (vDelay >= 0) begin pend[1] = 1'b1; pcnt[1] = pickDelay(); end
      end
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          pcnt[i]--;
          if (pcnt[i] == 0) begin
            pend[i] = 1'b0;
            SrcValid[i] = 1'b1;
            if (i == 0) SrcData0 = pdata[0];
            else        SrcData1 = pdata[1];
          end
        end
      end
      if (spurious && !SrcValid[1]) begin SrcValid[1] = 1'b1; SrcData1 = 8'hEE; end
      SrcReady = {q1.size() > 0, q0.size() > 0};
      case (busyMode)
        1:       TxBusy = ($urandom_range(0, 3) == 0);
        2:       TxBusy = 1'b1;
        default: TxBusy = 1'b0;
      endcase
    end
  end

  // Frame-level reference: whole bursts chosen round-robin, bytes taken straight from the queues.
  task automatic modelRun();
    logic s;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) s = mServed ? ~mLast : 1'b0;
      else s = (m1.size() > 0);
      expQ.push_back({4'hA, 3'b000, s});
      for (int k = 0; k < MAXB; k++) begin
        if (!s && m0.size() > 0)     expQ.push_back(m0.pop_front());
        else if (s && m1.size() > 0) expQ.push_back(m1.pop_front());
      end
      expQ.push_back({4'h5, 3'b000, s});
      mLast = s;
      mServed = 1;
    end
  endtask

  task automatic prep();
    m0 = q0; m1 = q1;
    expQ.delete(); gotQ.delete();
    modelRun();
  endtask

  task automatic waitGot(input int n, input int bound, input string name);
    int k = 0;
    while (gotQ.size() < n && k < bound) begin @(negedge SysClk); k++; end
    check({name, "_bound"}, {31'd0, gotQ.size() < n}, 32'd0);
  endtask

  task automatic finishFrames(input string name);
    int bad = -1;
    waitGot(expQ.size(), 4000, name);
    waitCycles(30);
    checks++;
    if (gotQ.size() != expQ.size()) bad = 0;
    foreach (expQ[i]) if (bad < 0 && gotQ[i] !== expQ[i]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: byte %0d actual=%0h required=%0h (count %0d vs %0d)",
               name, bad, gotQ[bad], expQ[bad], gotQ.size(), expQ.size());
    end
  endtask

  task automatic resetDut();
    @(posedge SysClk); #1 ResetN = 1'b0;
    repeat (2) @(posedge SysClk);
    #1 ResetN = 1'b1;
    mServed = 0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] lit34[5];
    logic [7:0] hold;
    bit changed;
    int k, startRd;
    ResetN = 1'b0;
    tbl[0] = '{0, 2, 4};   tbl[1] = '{4, 4, 12}; tbl[2] = '{5, 2, 13};
    tbl[3] = '{8, 8, 24};  tbl[4] = '{1, 9, 18}; tbl[5] = '{6, 0, 10};
    tbl[6] = '{3, 7, 16};
    lit34 = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h50};

    resetDut();
    @(negedge SysClk);
    check("rst_grant", {30'd0, Grant}, 0);
    check("rst_rden", {30'd0, SrcRdEn}, 0);
    check("rst_txstart", {31'd0, TxStart}, 0);
    check("rst_txdata", {24'd0, TxData}, 0);
    check("rst_timeout", {31'd0, TimeoutErr}, 0);

    for (int i = 0; i < 8; i++) begin q0.push_back(8'h10 + 8'(i)); q1.push_back(8'h20 + 8'(i)); end
    prep(); finishFrames("rr_alternate");
    check("rr_hdr0", {24'd0, gotQ[0]}, 32'hA0);
    check("rr_trl0", {24'd0, gotQ[5]}, 32'h50);
    check("rr_hdr1", {24'd0, gotQ[6]}, 32'hA1);
    check("rr_trl1", {24'd0, gotQ[11]}, 32'h51);

    q0 = '{8'h11, 8'h22, 8'h33};
    prep(); finishFrames("single_src");
    check("single_count", gotQ.size(), 5);
    for (int i = 0; i < 5; i++) check("single_lit", {24'd0, gotQ[i]}, {24'd0, lit34[i]});

    spurious = 1;
    q0 = '{8'hC3, 8'h3C, 8'h99};
    prep(); finishFrames("spurious_v1");
    spurious = 0;

    busyMode = 2;
    q0 = '{8'h42};
    prep(); waitCycles(5);
    hold = TxData; changed = 0;
    repeat (100) begin @(negedge SysClk); if (TxData !== hold) changed = 1; end
    check("busy_no_start", gotQ.size(), 0);
    check("busy_txdata", {24'd0, TxData}, 32'hA0);
    check("busy_stable", {31'd0, changed}, 0);
    busyMode = 0;
    finishFrames("busy_release");

    vDelay = 16;
    q0 = '{8'h5A};
    prep(); finishFrames("valid_at_expiry");
    check("expiry_no_err", {31'd0, TimeoutErr}, 0);

    vDelay = -1; toSeen = -1;
    gotQ.delete();
    q0 = '{8'h10};
    waitGot(2, 400, "timeout");
    waitCycles(20);
    check("timeout_count", gotQ.size(), 2);
    check("timeout_hdr", {24'd0, gotQ[0]}, 32'hA0);
    check("timeout_trl", {24'd0, gotQ[1]}, 32'h50);
    check("timeout_flag", {31'd0, TimeoutErr}, 1);
    check("timeout_latency", toSeen - rdCyc, 17);

    vDelay = 0;
    q0 = '{8'h61, 8'h62};
    prep(); finishFrames("after_timeout");
    check("timeout_sticky", {31'd0, TimeoutErr}, 1);

    vDelay = -1;
    gotQ.delete();
    startRd = rdCount;
    q0 = '{8'h66};
    k = 0;
    while (rdCount == startRd && k < 50) begin @(negedge SysClk); k++; end
    check("midreset_rden_bound", {31'd0, rdCount == startRd}, 0);
    waitCycles(3);
    @(posedge SysClk); #1 ResetN = 1'b0;
    @(posedge SysClk); @(negedge SysClk);
    check("midreset_grant", {30'd0, Grant}, 0);
    check("midreset_rden", {30'd0, SrcRdEn}, 0);
    check("midreset_txstart", {31'd0, TxStart}, 0);
    check("midreset_txdata", {24'd0, TxData}, 0);
    check("midreset_timeout", {31'd0, TimeoutErr}, 0);
    check("midreset_no_trl", gotQ.size(), 1);
    @(posedge SysClk); #1 ResetN = 1'b1;
    mServed = 0; vDelay = 0;
    q0 = '{8'h77};
    prep(); finishFrames("after_reset");
    check("after_reset_hdr", {24'd0, gotQ[0]}, 32'hA0);

    busyMode = 1;
    foreach (tbl[t]) begin
      for (int i = 0; i < tbl[t].n0; i++) q0.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < tbl[t].n1; i++) q1.push_back(8'($urandom_range(0, 255)));
      prep(); finishFrames($sformatf("table_%0d", t));
      check($sformatf("table_starts_%0d", t), gotQ.size(), tbl[t].expStarts);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_link_arbiter.md
TX_LINK_ARBITER -- requirements
Module: tx_link_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 256, meaning the maximum payload bytes per grant before re-arbitration (legal range 1..256).
REQ-002 The block SHALL have parameter VALID_TIMEOUT, default 16, meaning the maximum cycles to wait for SrcValid after SrcRdEn.
REQ-003 The block SHALL have port SysClk  in  1  system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port ResetN  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port SrcReady  in  2  per-source "bytes available" (FIFO not empty, or valid pending).
REQ-006 The block SHALL have port SrcValid  in  2  per-source byte valid, returned one or more cycles after SrcRdEn.
REQ-007 The block SHALL have ports SrcData0 and SrcData1  in  8 each  per-source byte data, sampled when the matching SrcValid is high.
REQ-008 The block SHALL have port SrcRdEn  out  2  per-source one-cycle read-enable pulse.
REQ-009 The block SHALL have port TxBusy  in  1  UART transmitter busy.
REQ-010 The block SHALL have port TxStart  out  1  one-cycle load pulse to the transmitter.
REQ-011 The block SHALL have port TxData  out  8  byte to transmit; stable from TxStart until the next TxStart.
REQ-012 The block SHALL have port Grant  out  2  one-hot granted source; 2'b00 when idle.
REQ-013 The block SHALL have port TimeoutErr  out  1  sticky flag set on a SrcValid timeout.

Function
REQ-014 States SHALL be IDLE, HDR, READ, WAIT_VALID, SEND, WAIT_TX and TRL, one-hot encoded.
REQ-015 IDLE: if either SrcReady is high, the block SHALL latch a grant and go to HDR; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both sources are ready, the source not served last is granted; the first grant after reset prefers source 0; a single ready source is granted immediately.
REQ-017 HDR: the block SHALL transmit the header byte {4'hA, 3'b000, src} and then go to READ.
REQ-018 READ: if SrcReady[src] is high and the burst count is below MAX_BURST, the block SHALL pulse SrcRdEn[src] for exactly one cycle and go to WAIT_VALID; otherwise it goes to TRL.
REQ-019 WAIT_VALID: on SrcValid[src] the block SHALL capture SrcData into TxData and go to SEND.
REQ-020 WAIT_VALID: after VALID_TIMEOUT cycles without SrcValid[src], the block SHALL set TimeoutErr and go to TRL.
REQ-021 SEND: when TxBusy is low, the block SHALL pulse TxStart, increment the 9-bit burst count and go to WAIT_TX.
REQ-022 WAIT_TX: the block SHALL stay at least 2 cycles, ignoring TxBusy in the first cycle, and then return to the saved next state when TxBusy is low.
REQ-023 Every transmitted byte (header, payload, trailer) SHALL use the SEND/WAIT_TX path.
REQ-024 TRL: the block SHALL transmit the trailer byte {4'h5, 3'b000, src}, record src as last-served, clear the burst count and Grant, and return to IDLE.
REQ-025 Exactly one SrcRdEn SHALL be outstanding at a time; SrcValid on the non-granted source SHALL be ignored.
REQ-026 SrcValid arriving in the same cycle as the timeout expiry SHALL be accepted as data, and TimeoutErr SHALL not be set.
REQ-027 SrcReady dropping after SrcRdEn SHALL NOT abort the outstanding byte.
REQ-028 When the burst count reaches MAX_BURST, the trailer SHALL be sent even if the source is still ready; the other source, if ready, wins the next arbitration.

Reset
REQ-029 While ResetN is low at a clock edge, the state SHALL go to IDLE and SrcRdEn, TxStart, Grant, TxData, TimeoutErr, burst count, timeout counter and last-served SHALL all be 0.
REQ-030 Reset mid-burst SHALL abandon the frame without sending a trailer.
REQ-031 TimeoutErr SHALL be cleared only by reset.

Structure
REQ-032 State encodings and the header/trailer nibble constants (4'hA, 4'h5) SHALL live in the shared package.
REQ-033 The round-robin selector SHALL be a sub-module named rr_arbiter2: inputs req[1:0] and last, output one-hot gnt.

Verification
REQ-034 Source 0 ready with 3 bytes (11,22,33), TxBusy low -> TxData sequence A0,11,22,33,50 and five TxStart pulses.
REQ-035 Both sources ready continuously, MAX_BURST=4 -> frames alternate, src0 first: A0+4 bytes+50, then A1+4 bytes+51.
REQ-036 SrcValid withheld after SrcRdEn for 16 cycles -> TimeoutErr=1, trailer 50 sent, return to IDLE.
REQ-037 TxBusy held high 100 cycles during SEND -> no TxStart until TxBusy falls; TxData stays unchanged.
REQ-038 ResetN driven low while in WAIT_VALID -> next cycle all outputs are 0 and state is IDLE; a subsequent burst starts with header A0.
REQ-039 Spurious SrcValid[1] during a source-0 grant -> ignored; the source-0 payload is unaltered.
